// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART TX scheduler: FSM states and address map.
package uart_tx_scheduler_pkg;

  localparam logic [31:0] TX_ADDR_DEFAULT    = 32'h0000_2001;
  localparam logic [31:0] UART_STATUS_OFFSET = 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT_DN = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// CPU write port / uart_tx handshake bundle for uart_tx_scheduler.
// Status read port present only when UART_TX_SCHED_STATUS_EN is defined.
interface uart_tx_scheduler_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;
  logic          stall;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_ready;
  logic [LW-1:0] fifo_level;
  logic          busy;
`ifdef UART_TX_SCHED_STATUS_EN
  logic          rd_en;
  logic [31:0]   rd_addr;
  logic [31:0]   status;

  modport master (
    output wr_en, wr_addr, wr_data, tx_ready, rd_en, rd_addr,
    input  stall, tx_data, tx_start, fifo_level, busy, status
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, tx_ready, rd_en, rd_addr,
    output stall, tx_data, tx_start, fifo_level, busy, status
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, tx_ready,
    input  stall, tx_data, tx_start, fifo_level, busy
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, tx_ready,
    output stall, tx_data, tx_start, fifo_level, busy
  );
`endif

endinterface

// File: rtl/uart_tx_scheduler_fifo.sv
// uart_tx_fifo: byte FIFO with first-word fall-through head and occupancy count.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    level_d = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Buffers CPU writes to TX_ADDR and launches uart_tx frames; stalls only when full.
// Optional status read port enabled by UART_TX_SCHED_STATUS_EN.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter logic [31:0] TX_ADDR    = TX_ADDR_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          SYNC_READY = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  uart_tx_scheduler_if.slave  bus
);
  tx_state_e  state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;
  logic       hit, push, pop, full, empty, rdy;
  logic [7:0] head;
  logic       unused_wr_data_hi;

  assign unused_wr_data_hi = ^bus.wr_data[31:8];

  assign hit  = bus.wr_en && (bus.wr_addr == TX_ADDR);
  assign push = hit && !full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (bus.wr_data[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (bus.fifo_level)
  );

  // Sync flops reset low so a frame left running across reset is waited out.
  if (SYNC_READY) begin : g_sync
    logic [1:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[0], bus.tx_ready};
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sync_q <= '0;
      else       sync_q <= sync_d;
    end
    assign rdy = sync_q[1];
  end else begin : g_nosync
    assign rdy = bus.tx_ready;
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && rdy) begin
          pop        = 1'b1;
          tx_data_d  = head;
          tx_start_d = 1'b1;
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH:  if (!rdy) state_d = ST_WAIT_DN;
      ST_WAIT_DN: if (rdy)  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign bus.stall    = hit && full;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = !empty || (state_q != ST_IDLE);

`ifdef UART_TX_SCHED_STATUS_EN
  logic [7:0] level8;
  always_comb begin
    level8     = 8'(bus.fifo_level);
    bus.status = '0;
    if (bus.rd_en && (bus.rd_addr == TX_ADDR + UART_STATUS_OFFSET))
      bus.status = {22'b0, level8, bus.busy, full};
  end
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: queue-based reference model plus a
// behavioural uart_tx whose ready flag drops for a programmable frame length.
module tb_uart_tx_scheduler;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] TXA   = 32'h0000_2001;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_scheduler #(
    .TX_ADDR    (TXA),
    .FIFO_DEPTH (DEPTH),
    .SYNC_READY (1'b1)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  int         cyc = 0;
  int         uart_cnt = 0;
  int         frame_len = 20;
  logic [2:0] rdy_hist = '1;
  logic       prev_start = 1'b0;
  logic       pushed = 1'b0;
  logic       stall_seen = 1'b0;
  logic       coincide2 = 1'b0;
  logic       inflight = 1'b0;
  int         rise_cyc = 0;
  int         meas_lat = 0;
  int         b2b_lat = 0;
  int         starts = 0;
  int         s0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check stall before the edge, then update the model from what the
  // edge must have done and compare against the DUT just after it.
  task automatic tick();
    logic       hit, do_push;
    logic [7:0] din;
    int         sz;
    #1;
    hit = bus.wr_en && (bus.wr_addr == TXA);
    chk("stall", bus.stall, hit && (q.size() == DEPTH));
    if (bus.stall) stall_seen = 1'b1;
    do_push = hit && rstn && (q.size() < DEPTH);
    din     = bus.wr_data[7:0];
    @(posedge clk);
    rdy_hist = {rdy_hist[1:0], bus.tx_ready};
    #1;
    cyc++;
    sz     = q.size();
    pushed = do_push;
    if (bus.tx_start) begin
      chk("start_nonempty", sz > 0, 1'b1);
      chk("start_rdy_synced", rdy_hist[2], 1'b1);
      chk("start_uart_idle", rdy_hist[0], 1'b1);
      chk("start_one_cycle", prev_start, 1'b0);
      if (sz > 0) begin
        chk("tx_data", bus.tx_data, q[0]);
        if (do_push && sz == 2) coincide2 = 1'b1;
        void'(q.pop_front());
      end
      meas_lat     = cyc - rise_cyc;
      starts++;
      uart_cnt     = frame_len;
      bus.tx_ready = 1'b0;
      inflight     = 1'b1;
    end else if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) begin
        bus.tx_ready = 1'b1;
        rise_cyc     = cyc;
        inflight     = 1'b0;
      end
    end
    if (do_push) q.push_back(din);
    prev_start = bus.tx_start;
    chk("level", bus.fifo_level, q.size());
    if (q.size() > 0 || inflight) chk("busy", bus.busy, 1'b1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    int n;
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    if (a != TXA) begin
      tick();
    end else begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!pushed && n < 3000);
      chk("wr_accepted", pushed, 1'b1);
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || uart_cnt > 0) && n < 5000) begin
      tick();
      n++;
    end
    chk("drain_queue", q.size(), 0);
    repeat (6) tick();
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_level", bus.fifo_level, 0);
    chk("idle_start", bus.tx_start, 1'b0);
  endtask

  initial begin
    rstn         = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.tx_ready = 1'b1;
`ifdef UART_TX_SCHED_STATUS_EN
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
`endif
    #12;
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_tx_start", bus.tx_start, 1'b0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_busy", bus.busy, 1'b0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (4) tick();

    // Single byte, exact launch latency
    frame_len = 20;
    s0 = starts;
    wr(TXA, 32'hDEAD_BE41);
    tick();
    chk("t1_latency_start", bus.tx_start, 1'b1);
    chk("t1_tx_data", bus.tx_data, 8'h41);
    tick();
    chk("t1_data_stable", bus.tx_data, 8'h41);
    drain();
    chk("t1_frames", starts - s0, 1);

    // Burst beyond depth: stall then ordered delivery
    frame_len  = 50;
    stall_seen = 1'b0;
    s0 = starts;
    for (int i = 0; i < 6; i++) wr(TXA, 32'h30 + 32'(i));
    chk("t2_stalled", stall_seen, 1'b1);
    drain();
    chk("t2_frames", starts - s0, 6);
    b2b_lat = (meas_lat < 1) ? 1 : meas_lat;

    // Neighbouring addresses ignored
    stall_seen = 1'b0;
    wr(32'h0000_2000, 32'h0000_0055);
    wr(32'h0000_2002, 32'h0000_0066);
    repeat (3) tick();
    chk("t3_no_stall", stall_seen, 1'b0);
    chk("t3_level", bus.fifo_level, 0);

    // Reset during WAIT_DN with three queued
    frame_len = 30;
    wr(TXA, 32'h70);
    repeat (6) tick();
    wr(TXA, 32'h71);
    wr(TXA, 32'h72);
    wr(TXA, 32'h73);
    chk("t4_level3", bus.fifo_level, 3);
    #2 rstn = 1'b0;
    #1;
    chk("t4_rst_stall", bus.stall, 1'b0);
    chk("t4_rst_start", bus.tx_start, 1'b0);
    chk("t4_rst_data", bus.tx_data, 8'h00);
    chk("t4_rst_level", bus.fifo_level, 0);
    chk("t4_rst_busy", bus.busy, 1'b0);
    q.delete();
    inflight = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    s0 = starts;
    wr(TXA, 32'h74);
    for (int n = 0; n < 200 && uart_cnt > 0; n++) tick();
    chk("t4_no_early_start", starts - s0, 0);
    chk("t4_tx_data_held", bus.tx_data, 8'h00);
    drain();
    chk("t4_frames", starts - s0, 1);

    // Push coinciding with pop at level 2
    frame_len = 20;
    coincide2 = 1'b0;
    wr(TXA, 32'h50);
    wr(TXA, 32'h51);
    wr(TXA, 32'h52);
    chk("t5_level2", bus.fifo_level, 2);
    for (int n = 0; n < 200 && uart_cnt > 0; n++) tick();
    repeat (b2b_lat - 1) tick();
    wr(TXA, 32'h53);
    chk("t5_coincide", coincide2, 1'b1);
    chk("t5_level_kept", bus.fifo_level, 2);
    drain();

`ifdef UART_TX_SCHED_STATUS_EN
    frame_len = 60;
    for (int i = 0; i < 5; i++) wr(TXA, 32'h60 + 32'(i));
    bus.rd_en   = 1'b1;
    bus.rd_addr = TXA + 32'd1;
    #1 chk("t6_status_full", bus.status, 32'h0000_0013);
    bus.rd_addr = TXA;
    #1 chk("t6_status_wrong_addr", bus.status, 32'h0);
    bus.rd_en   = 1'b0;
    bus.rd_addr = TXA + 32'd1;
    #1 chk("t6_status_no_rd", bus.status, 32'h0);
    drain();
`endif

    // Randomised traffic; CPU holds its write while stalled
    for (int i = 0; i < 300; i++) begin
      int r;
      frame_len = $urandom_range(3, 10);
      if (!(bus.wr_en && bus.wr_addr == TXA && q.size() == DEPTH)) begin
        r           = $urandom_range(0, 9);
        bus.wr_en   = ($urandom_range(0, 2) != 0);
        bus.wr_data = $urandom;
        case (r)
          6:       bus.wr_addr = 32'h0000_2000;
          7:       bus.wr_addr = 32'h0000_2002;
          8:       bus.wr_addr = $urandom;
          default: bus.wr_addr = TXA;
        endcase
      end
      tick();
    end
    bus.wr_en = 1'b0;
    drain();

    chk("end_queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
